// File: rtl/step_clk_pkg.sv
// Shared types and constants for the run/pause/step clock-enable controller.
package step_clk_pkg;

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    RUNNING = 2'd1,
    HALTED  = 2'd2
  } state_t;

  localparam logic [1:0] RATE_FULL = 2'd0;
  localparam logic [1:0] RATE_FAST = 2'd1;
  localparam logic [1:0] RATE_MED  = 2'd2;
  localparam logic [1:0] RATE_SLOW = 2'd3;

  localparam int TICK_W = 16;

endpackage

// File: rtl/step_clk_ctrl_sync_debounce.sv
// Two-flop synchroniser plus stable-level debouncer; pulses once per accepted press.
module sync_debounce #(
  parameter int DEBOUNCE = 500_000
) (
  input  logic fastclk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int DB_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

  logic            s1;
  logic            s2;
  logic            lvl;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // lvl is the accepted level; it only flips after DEBOUNCE consecutive disagreeing samples
  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      lvl   <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DEBOUNCE - 1)) begin
        lvl   <= s2;
        cnt   <= '0;
        pulse <= s2;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/step_clk_ctrl.sv
// Run/pause/single-step controller producing a one-cycle CPU clock enable.
module step_clk_ctrl
  import step_clk_pkg::*;
#(
  parameter int CNT_W    = 26,
  parameter int DIV_FAST = 1_000_000,
  parameter int DIV_MED  = 5_000_000,
  parameter int DIV_SLOW = 10_000_000,
  parameter int DEBOUNCE = 500_000
) (
  input  logic              fastclk,
  input  logic              rst_n,
  input  logic              run_sw,
  input  logic              step_btn,
  input  logic [1:0]        rate_sel,
  input  logic              halt_req,
  output logic              tick,
  output logic              slowclk,
  output logic [1:0]        state,
  output logic [TICK_W-1:0] tick_count
);

  logic             run_m;
  logic             run_s;
  logic             step_p;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       rate_q;
  logic [1:0]       rate_d;
  logic             tick_d;

  function automatic logic [CNT_W-1:0] div_last(input logic [1:0] r);
    case (r)
      RATE_FAST: return CNT_W'(DIV_FAST - 1);
      RATE_MED:  return CNT_W'(DIV_MED - 1);
      RATE_SLOW: return CNT_W'(DIV_SLOW - 1);
      default:   return '0;
    endcase
  endfunction

  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      run_m <= 1'b0;
      run_s <= 1'b0;
    end else begin
      run_m <= run_sw;
      run_s <= run_m;
    end
  end

  sync_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_step_db (
    .fastclk(fastclk),
    .rst_n  (rst_n),
    .raw    (step_btn),
    .pulse  (step_p)
  );

  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) state_q <= PAUSED;
    else        state_q <= state_d;
  end

  // halt beats a due tick; the rate is re-latched only at run entry and on each tick
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rate_d  = rate_q;
    tick_d  = 1'b0;
    case (state_q)
      RUNNING: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (!run_s) begin
          state_d = PAUSED;
        end else if (rate_q == RATE_FULL || cnt_q == div_last(rate_q)) begin
          tick_d = 1'b1;
          cnt_d  = '0;
          rate_d = rate_sel;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HALTED: begin
        if (!run_s) state_d = PAUSED;
      end
      default: begin
        if (run_s && !halt_req) begin
          state_d = RUNNING;
          cnt_d   = '0;
          rate_d  = rate_sel;
        end else if (step_p && !halt_req) begin
          tick_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rate_q     <= RATE_FULL;
      tick       <= 1'b0;
      slowclk    <= 1'b0;
      tick_count <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rate_q <= rate_d;
      tick   <= tick_d;
      if (tick_d) begin
        slowclk    <= ~slowclk;
        tick_count <= tick_count + TICK_W'(1);
      end
    end
  end

  assign state = state_q;

endmodule

// File: doc/step_clk_ctrl.md
Name: step_clk_ctrl

Overview:
Run/pause/single-step controller for the CPU clock-enable, clocked from the 50 MHz board clock.
- Emits a one-cycle `tick` enable at a selectable rate, or one `tick` per debounced step-button press.
- Provides a 50%-style `slowclk` that toggles per tick, for display LEDs.
- Sits between board switches/buttons and the CPU core, replacing free-running divided clocks with a single-domain enable.

Parameters:
CNT_W, 26, width of period counter
DIV_FAST, 1_000_000, fastclk cycles per tick for rate_sel=1 (min 2)
DIV_MED, 5_000_000, fastclk cycles per tick for rate_sel=2 (min 2)
DIV_SLOW, 10_000_000, fastclk cycles per tick for rate_sel=3 (min 2)
DEBOUNCE, 500_000, stable cycles required on step_btn before a press/release is accepted

Ports:
fastclk  in  1  50 MHz system clock; all logic on posedge
rst_n  in  1  asynchronous, active-low reset
run_sw  in  1  raw async run switch, 1=run
step_btn  in  1  raw async step button, active high
rate_sel  in  2  0=every cycle, 1=DIV_FAST, 2=DIV_MED, 3=DIV_SLOW
halt_req  in  1  synchronous halt request from CPU, level
tick  out  1  one-fastclk-cycle clock enable for CPU
slowclk  out  1  toggles on every tick
state  out  2  current FSM state (package encoding)
tick_count  out  16  number of ticks issued, wraps FFFF->0000

Behaviour:
- Reset (async assert, sync release): state=PAUSED, tick=0, slowclk=0, tick_count=0, period counter=0, debouncer disarmed, all sync flops 0.
- Synchronisers: run_sw and step_btn each pass through 2-flop synchronisers; run_s is the synced run_sw.
- Debounce:
  - Step press is accepted when the synced step_btn has been stable high for DEBOUNCE consecutive cycles; this yields a one-cycle step_p.
  - Re-arm requires stable low for DEBOUNCE cycles; holding the button yields exactly one step_p.
  - Latency from raw rising edge to step_p is 2+DEBOUNCE cycles.
- FSM states: PAUSED=0, RUNNING=1, HALTED=2 (3 unused; decodes to PAUSED).
  - PAUSED:
    - run_s=1 and halt_req=0 -> RUNNING; clear counter, latch rate_sel.
    - step_p=1 and halt_req=0 -> tick=1 on the next cycle; stay PAUSED.
    - step_p with halt_req=1 is dropped.
  - RUNNING:
    - halt_req=1 -> HALTED; any tick due that cycle is suppressed (halt wins).
    - Else run_s=0 -> PAUSED; no further ticks.
    - Else issue tick per rate.
    - step_p is ignored.
  - HALTED:
    - No ticks; step_p ignored.
    - run_s=0 -> PAUSED, regardless of halt_req.
    - A fresh run from PAUSED still requires halt_req=0.
- Rate timing:
  - rate 0: tick=1 every cycle while RUNNING; the first tick occurs the cycle after entering RUNNING.
  - rates 1-3:
    - Counter increments each RUNNING cycle.
    - When counter==DIV-1: tick=1, counter<=0.
    - The first tick occurs exactly DIV cycles after entering RUNNING.
  - rate_sel is re-latched only at entry to RUNNING and on each tick; mid-period changes take effect from the next period.
  - Counter holds its value outside RUNNING and is cleared on RUNNING entry.
- Outputs:
  - tick is registered, so it is never high for 2 consecutive cycles except at rate 0.
  - slowclk and tick_count update in the same cycle tick is high.
- Mid-operation reset: all of the above return immediately to reset values; no pending step survives.

Decomposition:
- Package step_clk_pkg holds:
  - state enum (PAUSED, RUNNING, HALTED);
  - rate codes RATE_FULL/FAST/MED/SLOW;
  - 16-bit tick_count width constant.
- One sub-module, sync_debounce: 2-flop sync, DEBOUNCE counter, rising-edge pulse output.
  - Instanced for step_btn only.
  - run_sw uses a bare 2-flop sync inside the top.

Test Plan (DIV_FAST=3, DIV_MED=5, DIV_SLOW=10, DEBOUNCE=4):
- Reset, run_sw=1, rate_sel=3, hold 35 cycles -> 3 ticks at cycles 10/20/30 after RUNNING entry; tick_count=3; slowclk=1.
- PAUSED, step_btn high 20 cycles with 1-cycle glitches before it -> glitches give no tick; exactly 1 tick, 7 cycles after the stable edge; tick_count=1.
- RUNNING at rate 2, switch rate_sel to 1 at cycle 2 -> next tick at cycle 5; subsequent ticks every 3 cycles.
- RUNNING at rate 1, halt_req rises on the cycle a tick is due -> no tick; state=HALTED. Step press gives no tick. run_sw=0 -> PAUSED. run_sw=1 with halt_req=0 -> RUNNING.
- rate 0 with tick_count preloaded to FFFE (via 65534 ticks) -> two more ticks give tick_count 0000; tick is high on consecutive cycles.
- rst_n pulsed low mid-period and mid-debounce -> outputs zero immediately (async); after release, no stale tick or step occurs.
